// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter for the 16-bit core register-file write port.
// Merges load results (highest priority) and ALU results onto one write port,
// parks ALU results in a 2-entry skid FIFO while loads win, and tracks
// outstanding loads in an 8-bit busy scoreboard for decode-stage stalls.
// Optional build macro: WB_R0_DISCARD_EN (register 0 hard-wired to zero).
//
// Handshake: an ALU result transfers on a cycle where alu_valid_i and
// alu_ready_o are both high; alu_ready_o depends only on the FIFO state, and
// upstream holds alu_* stable while alu_valid_i is high and alu_ready_o low.
// Load results (mem_valid_i) are always accepted.
module wb_arbiter (
   input  logic        clk_i,
   input  logic        rst,
   input  logic        alu_valid_i,
   input  logic [2:0]  alu_adr_i,
   input  logic [15:0] alu_data_i,
   output logic        alu_ready_o,
   input  logic        mem_valid_i,
   input  logic [2:0]  mem_adr_i,
   input  logic [15:0] mem_data_i,
   input  logic        ld_issue_i,
   input  logic [2:0]  ld_adr_i,
   output logic        wr_ena_o,
   output logic [2:0]  wr_adr_o,
   output logic [15:0] wr_data_o,
   output logic [7:0]  busy_o
);

   // FIFO occupancy; state_q is the observable FSM state for checkers.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fifo_state_t;

   fifo_state_t state_q, state_d;

   logic [2:0]  fifo_adr_q  [2];
   logic [15:0] fifo_data_q [2];
   logic        head_q, tail_q;

   logic        alu_xfer;
   logic        enq, deq;
   logic        commit;
   logic        wr_en_d;
   logic [2:0]  sel_adr;
   logic [15:0] sel_data;
   logic [7:0]  busy_d;

   assign alu_ready_o = (state_q != FULL);
   assign alu_xfer    = alu_valid_i & alu_ready_o;

   // Source selection: load result, then FIFO head, then ALU bypass.
   always_comb begin
      enq      = 1'b0;
      deq      = 1'b0;
      commit   = 1'b0;
      sel_adr  = 3'd0;
      sel_data = 16'h0000;
      if (mem_valid_i) begin
         commit   = 1'b1;
         sel_adr  = mem_adr_i;
         sel_data = mem_data_i;
         enq      = alu_xfer;
      end else if (state_q != EMPTY) begin
         commit   = 1'b1;
         deq      = 1'b1;
         sel_adr  = fifo_adr_q[head_q];
         sel_data = fifo_data_q[head_q];
         enq      = alu_xfer;
      end else if (alu_xfer) begin
         commit   = 1'b1;
         sel_adr  = alu_adr_i;
         sel_data = alu_data_i;
      end
`ifdef WB_R0_DISCARD_EN
      // Writes to register 0 are consumed but never reach the register file.
      wr_en_d = commit & (sel_adr != 3'd0);
`else
      wr_en_d = commit;
`endif
   end

   // FIFO occupancy next-state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (enq && !deq) state_d = ONE;
         ONE: begin
            if (enq && !deq)      state_d = FULL;
            else if (deq && !enq) state_d = EMPTY;
         end
         FULL:    if (deq) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   // Scoreboard: clear on load commit, then set on issue so a back-to-back
   // load to the same register stays busy.
   always_comb begin
      busy_d = busy_o;
      if (mem_valid_i) busy_d[mem_adr_i] = 1'b0;
`ifdef WB_R0_DISCARD_EN
      if (ld_issue_i && (ld_adr_i != 3'd0)) busy_d[ld_adr_i] = 1'b1;
`else
      if (ld_issue_i) busy_d[ld_adr_i] = 1'b1;
`endif
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   // FIFO storage and pointers; contents are discarded on reset.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         head_q <= 1'b0;
         tail_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_adr_q[i]  <= 3'd0;
            fifo_data_q[i] <= 16'h0000;
         end
      end else begin
         if (enq) begin
            fifo_adr_q[tail_q]  <= alu_adr_i;
            fifo_data_q[tail_q] <= alu_data_i;
         end
         head_q <= head_q ^ deq;
         tail_q <= tail_q ^ enq;
      end
   end

   // Registered write port and busy vector; address/data hold when idle.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         wr_ena_o  <= 1'b0;
         wr_adr_o  <= 3'd0;
         wr_data_o <= 16'h0000;
         busy_o    <= 8'h00;
      end else begin
         wr_ena_o <= wr_en_d;
         if (wr_en_d) begin
            wr_adr_o  <= sel_adr;
            wr_data_o <= sel_data;
         end
         busy_o <= busy_d;
      end
   end

endmodule
